// File: rtl/irq_ctrl.sv
// Edge-triggered, fixed-priority interrupt controller with an IDLE/ASSERT/SERVICE handshake.
// Define IRQ_CTRL_SYNC_EN to add a 2-flop synchronizer on every irq_src bit.
module irq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_src,
    input  logic       irq_en_we,
    input  logic [7:0] irq_en_wd,
    input  logic       interrupt_enable,
    input  logic       irq_ack,
    input  logic       irq_complete,
    output logic [7:0] interrupt_flag,
    output logic [2:0] irq_id,
    output logic [7:0] irq_pending,
    output logic [7:0] irq_en,
    output logic       irq_busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [7:0] srcSampled;

`ifdef IRQ_CTRL_SYNC_EN
    // Arm delay also covers the synchronizer fill, so a level held through reset is not seen as an edge.
    localparam int ARM_W = 3;

    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign srcSampled = sync2_q;
`else
    localparam int ARM_W = 1;

    assign srcSampled = irq_src;
`endif

    logic [ARM_W-1:0] arm_q;
    logic [7:0]       srcPrev_q;
    logic [7:0]       pending_q, pending_d;
    logic [7:0]       en_q, en_d;
    logic [7:0]       flag_q, flag_d;
    logic [2:0]       id_q, id_d;
    logic [1:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic [7:0]       edgeDet;
    logic [7:0]       clrMask;
    logic [2:0]       cand;
    logic             candValid;

    assign edgeDet = srcSampled & ~srcPrev_q & {8{arm_q[ARM_W-1]}};

    // The first sample(s) after reset only prime srcPrev_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_q     <= '0;
            srcPrev_q <= 8'h00;
        end else begin
            arm_q     <= (arm_q << 1) | ARM_W'(1);
            srcPrev_q <= srcSampled;
        end
    end

    always_comb begin
        cand      = 3'd0;
        candValid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i] && en_q[i]) begin
                cand      = 3'(i);
                candValid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        id_d    = id_q;
        clrMask = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (interrupt_enable && candValid) begin
                    id_d    = cand;
                    flag_d  = 8'h01 << cand;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // Ack beats a same-cycle disable of the asserted source.
                if (irq_ack) begin
                    flag_d  = 8'h00;
                    clrMask = 8'h01 << id_q;
                    state_d = ST_SERVICE;
                end else if (irq_en_we && !irq_en_wd[id_q]) begin
                    flag_d  = 8'h00;
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                flag_d = 8'h00;
                if (irq_complete) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                flag_d  = 8'h00;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pending_d = (pending_q & ~clrMask) | edgeDet;
    assign en_d      = irq_en_we ? irq_en_wd : en_q;
    assign busy_d    = (state_d != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            flag_q    <= 8'h00;
            id_q      <= 3'd0;
            pending_q <= 8'h00;
            en_q      <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            flag_q    <= flag_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
        end
    end

    assign interrupt_flag = flag_q;
    assign irq_id         = id_q;
    assign irq_pending    = pending_q;
    assign irq_en         = en_q;
    assign irq_busy       = busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected {flag,id} per assertion, a monitor checks them.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] irqSrc = 8'h00;
    logic       enWe = 1'b0;
    logic [7:0] enWd = 8'h00;
    logic       mie = 1'b0;
    logic       ack = 1'b0;
    logic       complete = 1'b0;
    logic [7:0] flag;
    logic [2:0] id;
    logic [7:0] pending;
    logic [7:0] en;
    logic       busy;

    int total = 0;
    int bad = 0;
    logic [10:0] expQ[$];
    logic [7:0]  prevFlag = 8'h00;

    irq_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .irq_src          (irqSrc),
        .irq_en_we        (enWe),
        .irq_en_wd        (enWd),
        .interrupt_enable (mie),
        .irq_ack          (ack),
        .irq_complete     (complete),
        .interrupt_flag   (flag),
        .irq_id           (id),
        .irq_pending      (pending),
        .irq_en           (en),
        .irq_busy         (busy)
    );

    always #5 clk = ~clk;

    // Every new assertion of interrupt_flag must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && flag != 8'h00 && prevFlag == 8'h00) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_assert: got flag=%h id=%0d, required no assertion", flag, id);
            end else begin
                logic [10:0] e;
                e = expQ.pop_front();
                if ({flag, id} !== e) begin
                    bad++;
                    $display("[TB] FAIL assert_event: got flag=%h id=%0d, required flag=%h id=%0d",
                             flag, id, e[10:3], e[2:0]);
                end
            end
        end
        prevFlag = flag;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Strobes (we/ack/complete) last one clock edge; src and MIE persist for all cycles.
    task automatic applyStimulus(input logic [7:0] src, input logic m, input logic a, input logic c,
                                 input logic we, input logic [7:0] wd, input int cycles);
        irqSrc   = src;
        mie      = m;
        ack      = a;
        complete = c;
        enWe     = we;
        enWd     = wd;
        @(posedge clk);
        #1;
        ack      = 1'b0;
        complete = 1'b0;
        enWe     = 1'b0;
        repeat (cycles - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectAssert(input logic [7:0] f, input logic [2:0] i);
        expQ.push_back({f, i});
    endtask

    initial begin
        #3;
        checkOutput("reset_flag", 32'(flag), 32'h0);
        checkOutput("reset_id", 32'(id), 32'h0);
        checkOutput("reset_pending", 32'(pending), 32'h0);
        checkOutput("reset_en", 32'(en), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] single timer source");
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1);
        checkOutput("t1_en", 32'(en), 32'h01);
        expectAssert(8'h01, 3'd0);
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1 + LAT);
        checkOutput("t1_pending", 32'(pending), 32'h01);
        checkOutput("t1_flag_not_yet", 32'(flag), 32'h0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        checkOutput("t1_busy_assert", 32'(busy), 32'h1);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        checkOutput("t1_flag_after_ack", 32'(flag), 32'h0);
        checkOutput("t1_pending_after_ack", 32'(pending), 32'h0);
        checkOutput("t1_busy_service", 32'(busy), 32'h1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        checkOutput("t1_busy_idle", 32'(busy), 32'h0);

        $display("[TB] priority between bits 5 and 2");
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1);
        expectAssert(8'h04, 3'd2);
        expectAssert(8'h20, 3'd5);
        applyStimulus(8'h24, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1 + LAT);
        checkOutput("t2_pending", 32'(pending), 32'h24);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2);
        checkOutput("t2_mie_off_keeps_flag", 32'(flag), 32'h04);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        checkOutput("t2_pending_after_ack", 32'(pending), 32'h20);
        checkOutput("t2_busy_service", 32'(busy), 32'h1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        checkOutput("t2_idle_gap_flag", 32'(flag), 32'h0);
        checkOutput("t2_idle_gap_busy", 32'(busy), 32'h0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        checkOutput("t2_second_id", 32'(id), 32'd5);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);

        $display("[TB] withdraw by disabling id 3");
        expectAssert(8'h08, 3'd3);
        applyStimulus(8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1 + LAT);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF7, 1);
        checkOutput("t3_withdraw_flag", 32'(flag), 32'h0);
        checkOutput("t3_withdraw_busy", 32'(busy), 32'h0);
        checkOutput("t3_pending_kept", 32'(pending), 32'h08);
        checkOutput("t3_en", 32'(en), 32'hF7);
        expectAssert(8'h08, 3'd3);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1);
        checkOutput("t3_reenable_flag_wait", 32'(flag), 32'h0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);

        $display("[TB] new edge during ack on bit 1");
        expectAssert(8'h02, 3'd1);
        applyStimulus(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1 + LAT);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1 + LAT);
        if (LAT > 0) applyStimulus(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, LAT);
        applyStimulus(8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        checkOutput("t4_pending_edge_wins", 32'(pending), 32'h02);
        checkOutput("t4_busy_service", 32'(busy), 32'h1);
        expectAssert(8'h02, 3'd1);
        applyStimulus(8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        applyStimulus(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);

        $display("[TB] ack beats same-cycle disable");
        expectAssert(8'h40, 3'd6);
        applyStimulus(8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1 + LAT);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1);
        checkOutput("t6_busy_service", 32'(busy), 32'h1);
        checkOutput("t6_en_written", 32'(en), 32'h00);
        checkOutput("t6_pending_cleared", 32'(pending), 32'h00);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);

        $display("[TB] global enable gating and reset");
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1);
        applyStimulus(8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1 + LAT);
        checkOutput("t5_pending", 32'(pending), 32'h10);
        applyStimulus(8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3);
        checkOutput("t5_mie_off_flag", 32'(flag), 32'h0);
        expectAssert(8'h10, 3'd4);
        applyStimulus(8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        applyStimulus(8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        checkOutput("t5_busy_service", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("t5_rst_flag", 32'(flag), 32'h0);
        checkOutput("t5_rst_id", 32'(id), 32'h0);
        checkOutput("t5_rst_pending", 32'(pending), 32'h0);
        checkOutput("t5_rst_en", 32'(en), 32'h0);
        checkOutput("t5_rst_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4 + LAT);
        checkOutput("t5_no_edge_after_release", 32'(pending), 32'h0);
        checkOutput("t5_flag_after_release", 32'(flag), 32'h0);

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: irq_src  input  8  raw level interrupt sources; bit 0 = timer.
REQ-004 SHALL have: irq_en_we  input  1  enable-mask write strobe.
REQ-005 SHALL have: irq_en_wd  input  8  enable-mask write data.
REQ-006 SHALL have: interrupt_enable  input  1  global enable (mstatus.MIE).
REQ-007 SHALL have: irq_ack  input  1  trap sequencer has taken the asserted interrupt.
REQ-008 SHALL have: irq_complete  input  1  handler finished (mret retired).
REQ-009 SHALL have: interrupt_flag  output  8  one-hot asserted source, registered.
REQ-010 SHALL have: irq_id  output  3  index of claimed/asserted source.
REQ-011 SHALL have: irq_pending  output  8  pending register.
REQ-012 SHALL have: irq_en  output  8  enable-mask register.
REQ-013 SHALL have: irq_busy  output  1  high in ASSERT or SERVICE.

Function
REQ-014 SHALL detect rising edges per source on the sampled input (previous-sample register); edge sets pending[i] at the next clk edge.
REQ-015 SHALL clear pending[id] on the clk edge where irq_ack=1 in ASSERT; a same-cycle new edge on that source SHALL win (pending stays 1).
REQ-016 SHALL load irq_en from irq_en_wd on the clk edge with irq_en_we=1, in any state.
REQ-017 SHALL select the candidate = lowest index i with pending[i] & irq_en[i] (fixed priority, bit 0 highest).
REQ-018 SHALL implement FSM IDLE -> ASSERT -> SERVICE -> IDLE, state held in registers.
REQ-019 IDLE: if interrupt_enable=1 and a candidate exists, SHALL latch irq_id, set interrupt_flag = one-hot(id), go ASSERT; else stay.
REQ-020 ASSERT: SHALL hold interrupt_flag and irq_id stable until irq_ack=1, then clear interrupt_flag to 0 and go SERVICE.
REQ-021 ASSERT: if irq_en[id] is written to 0 (and no same-cycle irq_ack), SHALL withdraw: interrupt_flag=0, go IDLE, pending[id] kept.
REQ-022 ASSERT: irq_ack has priority over a same-cycle disable (REQ-021 not applied).
REQ-023 ASSERT: deassertion of interrupt_enable SHALL NOT withdraw the flag.
REQ-024 SERVICE: interrupt_flag=0; irq_id held; on irq_complete=1 go IDLE; no nesting, new pending bits accumulate.
REQ-025 SHALL ignore irq_ack outside ASSERT and irq_complete outside SERVICE.
REQ-026 Latency (macro off): src rises before edge N -> pending visible after N -> interrupt_flag visible after N+1 (IDLE, enabled).
REQ-027 After SERVICE->IDLE, next candidate SHALL be asserted one cycle later at earliest (IDLE must be occupied one cycle).
REQ-028 irq_pending, irq_en, irq_busy SHALL be direct register outputs.

Reset
REQ-029 On rst=0, immediately: state=IDLE, interrupt_flag=0, irq_id=0, irq_pending=0, irq_en=0, irq_busy=0, edge-sample and synchronizer registers=0.
REQ-030 Reset mid-ASSERT/SERVICE SHALL drop the flag at once; sources already high at release SHALL NOT create pending (no edge).

Configuration
REQ-031 Macro IRQ_CTRL_SYNC_EN: when defined, each irq_src bit SHALL pass a 2-flop synchronizer before edge detection, adding 2 cycles to REQ-026; when undefined, irq_src feeds edge detection directly and is required to be synchronous to clk.

Verification
REQ-032 irq_en=0x01, MIE=1, irq_src[0] 0->1 -> pending=0x01 next cycle, interrupt_flag=0x01, irq_id=0 following cycle (+2 cycles with macro).
REQ-033 irq_en=0xFF, edges on bits 5 and 2 same cycle -> flag=0x04, id=2; ack -> pending=0x20, SERVICE; complete -> flag=0x20, id=5 two cycles later.
REQ-034 In ASSERT id=3, write irq_en=0xF7 with no ack -> flag=0x00, state IDLE, pending[3]=1; rewrite 0xFF -> flag=0x08 again.
REQ-035 In ASSERT id=1, ack same cycle as new edge on bit 1 -> pending[1] stays 1, SERVICE; complete -> flag=0x02 reasserted.
REQ-036 MIE=0 with pending=0x10, irq_en=0x10 -> flag stays 0; MIE=1 -> flag=0x10 next cycle; rst pulse in SERVICE -> all outputs 0 immediately.
